// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU for the MIPS core. Decodes ALUOp + funct, computes the
//   result and registers it with a one-cycle out_valid pulse. multu runs on a
//   WIDTH-cycle shift-add multiplier and writes the HI/LO registers.
//
// Parameters
//   WIDTH   datapath width in bits (>= 8)
//   MUL_EN  1 enables multu/mfhi/mflo, 0 decodes them as illegal
//   SH_W    shift-amount width, derived from WIDTH
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         operation presented
//   in_ready         unit can accept (handshake = in_valid && in_ready)
//   alu_op, funct    control-unit ALUOp and R-format funct field
//   shamt            shift amount for sll/srl
//   a, b             operands (rs, rt)
//   out_valid        one-cycle pulse, result/zero/illegal valid
//   result, zero     registered result and (result == 0)
//   illegal          registered, qualifies out_valid
//   hi, lo           multiply result registers
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new op; single-cycle ops complete from here
// MUL   | multu in flight, one shift-add step per cycle, in_ready low

module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1,
    parameter int SH_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [SH_W-1:0]  shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;

    logic [WIDTH-1:0]     dec_result;
    logic                 dec_illegal;
    logic                 dec_mul;
    logic                 accept;

    assign accept = in_valid && in_ready;

    // Illegal codes leave dec_result at 0 so the registered result/zero
    // fall out of the same path as legal ops.
    always_comb begin
        dec_result  = '0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        case (alu_op)
            2'b00: dec_result = a + b;
            2'b01: dec_result = a - b;
            2'b10: begin
                case (funct)
                    FN_ADD: dec_result = a + b;
                    FN_SUB: dec_result = a - b;
                    FN_AND: dec_result = a & b;
                    FN_OR:  dec_result = a | b;
                    FN_NOR: dec_result = ~(a | b);
                    FN_SLT: dec_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    FN_SLL: dec_result = b << shamt;
                    FN_SRL: dec_result = b >> shamt;
                    FN_MULTU: begin
                        if (MUL_EN != 0) dec_mul = 1'b1;
                        else             dec_illegal = 1'b1;
                    end
                    FN_MFHI: begin
                        if (MUL_EN != 0) dec_result = hi;
                        else             dec_illegal = 1'b1;
                    end
                    FN_MFLO: begin
                        if (MUL_EN != 0) dec_result = lo;
                        else             dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Accumulator value after this cycle's shift-add step.
    always_comb begin
        acc_step = acc;
        if (mplier[0]) acc_step = acc + mcand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_mul) begin
                            mcand    <= {{WIDTH{1'b0}}, a};
                            mplier   <= b;
                            acc      <= '0;
                            cnt      <= CNT_W'(WIDTH);
                            in_ready <= 1'b0;
                            state    <= MUL;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= dec_result;
                            zero      <= (dec_result == '0);
                            illegal   <= dec_illegal;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Last step: the counter hits its terminal count on this edge.
                    if (cnt == CNT_W'(1)) begin
                        hi        <= acc_step[2*WIDTH-1:WIDTH];
                        lo        <= acc_step[WIDTH-1:0];
                        result    <= acc_step[WIDTH-1:0];
                        zero      <= (acc_step[WIDTH-1:0] == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps

module tb_alu_exec_unit;

    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLL = 6'h00, F_SRL = 6'h02;
    localparam logic [5:0] F_MULTU = 6'h19, F_MFHI = 6'h10, F_MFLO = 6'h12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // 32-bit, multiplier enabled
    logic        v32 = 0;
    logic [1:0]  op32 = 0;
    logic [5:0]  fn32 = 0;
    logic [4:0]  sh32 = 0;
    logic [31:0] a32 = 0, b32 = 0;
    logic        rdy32, ov32, z32, ill32;
    logic [31:0] res32, hi32, lo32;

    // 8-bit, multiplier enabled
    logic        v8 = 0;
    logic [1:0]  op8 = 0;
    logic [5:0]  fn8 = 0;
    logic [2:0]  sh8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        rdy8, ov8, z8, ill8;
    logic [7:0]  res8, hi8, lo8;

    // 32-bit, multiplier disabled
    logic        vn = 0;
    logic [1:0]  opn = 0;
    logic [5:0]  fnn = 0;
    logic [4:0]  shn = 0;
    logic [31:0] an = 0, bn = 0;
    logic        rdyn, ovn, zn, illn;
    logic [31:0] resn, hin, lon;

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
        .alu_op(op32), .funct(fn32), .shamt(sh32), .a(a32), .b(b32),
        .out_valid(ov32), .result(res32), .zero(z32), .illegal(ill32),
        .hi(hi32), .lo(lo32)
    );

    alu_exec_unit #(.WIDTH(8), .MUL_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .alu_op(op8), .funct(fn8), .shamt(sh8), .a(a8), .b(b8),
        .out_valid(ov8), .result(res8), .zero(z8), .illegal(ill8),
        .hi(hi8), .lo(lo8)
    );

    alu_exec_unit #(.WIDTH(32), .MUL_EN(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .in_valid(vn), .in_ready(rdyn),
        .alu_op(opn), .funct(fnn), .shamt(shn), .a(an), .b(bn),
        .out_valid(ovn), .result(resn), .zero(zn), .illegal(illn),
        .hi(hin), .lo(lon)
    );

    // Architectural HI/LO as the bench believes them to be.
    logic [31:0] m_hi = 0, m_lo = 0;

    // Reference: returns {illegal, result} for a single-cycle op.
    function automatic logic [32:0] ref32(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [4:0] sh, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        int signed sx, sy;
        sx = x;
        sy = y;
        if (op == 2'd0) return {1'b0, x + y};
        if (op == 2'd1) return {1'b0, x - y};
        if (op == 2'd3) return {1'b1, 32'd0};
        case (fn)
            F_ADD:  return {1'b0, x + y};
            F_SUB:  return {1'b0, x - y};
            F_AND:  return {1'b0, x & y};
            F_OR:   return {1'b0, x | y};
            F_NOR:  return {1'b0, ~(x | y)};
            F_SLT:  return {1'b0, (sx < sy) ? 32'd1 : 32'd0};
            F_SLL:  return {1'b0, 32'(64'(y) * (64'd1 << sh))};
            F_SRL:  return {1'b0, y / (32'd1 << sh)};
            F_MFHI: return {1'b0, h};
            F_MFLO: return {1'b0, l};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic do_op32(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op32 = op; fn32 = fn; sh32 = sh; a32 = x; b32 = y; v32 = 1'b1;
        @(posedge clk);
        #1 v32 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({rdy32, ov32, res32, z32, ill32, hi32, lo32} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got rdy=%b ov=%b res=%h z=%b ill=%b hi=%h lo=%h expected rdy=1 ov=0 res=0 z=0 ill=0 hi=0 lo=0",
                     rdy32, ov32, res32, z32, ill32, hi32, lo32);
        end
        rst_n = 1'b1;
        do_op32(2'b10, F_ADD, 0, 32'd7, 32'd5);
        tests_run++;
        if ({ov32, res32} !== {1'b1, 32'd12}) begin
            tests_failed++;
            $display("FAIL pre_reset_add: got ov=%b res=%h expected ov=1 res=0000000c", ov32, res32);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rdy32, ov32, res32, z32, ill32, hi32, lo32} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: got rdy=%b ov=%b res=%h z=%b ill=%b expected rdy=1 ov=0 res=0 z=0 ill=0",
                     rdy32, ov32, res32, z32, ill32);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode;
        logic [5:0]  fns [6];
        logic [31:0] exp_r [6];
        fns   = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
        exp_r = '{32'd12, 32'd2, 32'd5, 32'd7, 32'hFFFF_FFF8, 32'd0};
        for (int i = 0; i < 6; i++) begin
            do_op32(2'b10, fns[i], 0, 32'd7, 32'd5);
            tests_run++;
            if ({ov32, ill32, z32, res32} !== {1'b1, 1'b0, (exp_r[i] == 0), exp_r[i]}) begin
                tests_failed++;
                $display("FAIL decode_funct_%h: got ov=%b ill=%b z=%b res=%h expected res=%h",
                         fns[i], ov32, ill32, z32, res32, exp_r[i]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (ov32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL out_valid_pulse: got ov=%b expected 0 two cycles after accept", ov32);
        end
        do_op32(2'b10, F_SLT, 0, 32'hFFFF_FFFF, 32'd1);
        tests_run++;
        if ({ov32, res32} !== {1'b1, 32'd1}) begin
            tests_failed++;
            $display("FAIL slt_signed: got ov=%b res=%h expected 1", ov32, res32);
        end
        do_op32(2'b01, 6'h3F, 0, 32'd9, 32'd9);
        tests_run++;
        if ({ov32, ill32, z32, res32} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
            tests_failed++;
            $display("FAIL beq_sub_zero: got ill=%b z=%b res=%h expected ill=0 z=1 res=0", ill32, z32, res32);
        end
    endtask

    task automatic test_shifts;
        do_op32(2'b10, F_SLL, 5'd31, 32'd0, 32'd1);
        tests_run++;
        if ({ov32, res32} !== {1'b1, 32'h8000_0000}) begin
            tests_failed++;
            $display("FAIL sll_31: got res=%h expected 80000000", res32);
        end
        do_op32(2'b10, F_SRL, 5'd31, 32'd0, 32'h8000_0000);
        tests_run++;
        if ({ov32, res32} !== {1'b1, 32'd1}) begin
            tests_failed++;
            $display("FAIL srl_31: got res=%h expected 00000001", res32);
        end
    endtask

    task automatic test_multiply;
        logic [31:0] x, y;
        logic [63:0] p;
        int bad;
        for (int i = 0; i < 5; i++) begin
            x = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            y = (i == 0) ? 32'hFFFF_FFFF : ((i == 1) ? 32'd0 : $urandom);
            p = 64'(x) * 64'(y);
            @(negedge clk);
            op32 = 2'b10; fn32 = F_MULTU; a32 = x; b32 = y; v32 = 1'b1;
            @(posedge clk);
            #1;
            if (i == 0) fn32 = F_MFHI;   // issuer holds the next op while stalled
            else        v32 = 1'b0;
            bad = 0;
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                if (rdy32 !== 1'b0 || ov32 !== 1'b0) bad++;
            end
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL mul_busy_%0d: got %0d cycles with rdy/ov wrong expected 0", i, bad);
            end
            @(negedge clk);
            tests_run++;
            if ({ov32, rdy32, ill32, z32, res32, hi32, lo32} !== {1'b1, 1'b1, 1'b0, (p[31:0] == 0), p[31:0], p[63:32], p[31:0]}) begin
                tests_failed++;
                $display("FAIL mul_done_%0d: got ov=%b rdy=%b ill=%b z=%b res=%h hi=%h lo=%h expected hi=%h lo=%h",
                         i, ov32, rdy32, ill32, z32, res32, hi32, lo32, p[63:32], p[31:0]);
            end
            m_hi = p[63:32];
            m_lo = p[31:0];
            if (i == 0) begin
                @(posedge clk);
                #1 v32 = 1'b0;
                @(negedge clk);
                tests_run++;
                if ({ov32, ill32, res32} !== {1'b1, 1'b0, 32'hFFFF_FFFE}) begin
                    tests_failed++;
                    $display("FAIL mfhi_after_mul: got ov=%b res=%h expected ov=1 res=fffffffe", ov32, res32);
                end
            end
        end
    endtask

    task automatic test_illegal;
        do_op32(2'b10, 6'h3F, 0, 32'd3, 32'd4);
        tests_run++;
        if ({ov32, ill32, z32, res32, hi32, lo32} !== {1'b1, 1'b1, 1'b1, 32'd0, m_hi, m_lo}) begin
            tests_failed++;
            $display("FAIL illegal_funct: got ill=%b z=%b res=%h hi=%h lo=%h expected ill=1 z=1 res=0 hi=%h lo=%h",
                     ill32, z32, res32, hi32, lo32, m_hi, m_lo);
        end
        do_op32(2'b11, F_ADD, 0, 32'd3, 32'd4);
        tests_run++;
        if ({ov32, ill32, z32, res32} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
            tests_failed++;
            $display("FAIL illegal_aluop: got ill=%b z=%b res=%h expected ill=1 z=1 res=0", ill32, z32, res32);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0]  tab [11];
        logic [32:0] e, e_prev;
        int r;
        tab = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLL, F_SRL, F_MFHI, F_MFLO, 6'h3F};
        e_prev = '0;
        for (int i = 0; i <= 150; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests_run++;
                if ({rdy32, ov32, ill32, z32, res32} !== {1'b1, 1'b1, e_prev[32], (e_prev[31:0] == 0), e_prev[31:0]}) begin
                    tests_failed++;
                    $display("FAIL b2b_op_%0d: got rdy=%b ov=%b ill=%b z=%b res=%h expected ill=%b res=%h",
                             i - 1, rdy32, ov32, ill32, z32, res32, e_prev[32], e_prev[31:0]);
                end
            end
            if (i < 150) begin
                r = $urandom_range(0, 7);
                op32 = (r < 2) ? 2'(r) : ((r == 7) ? 2'b11 : 2'b10);
                fn32 = tab[$urandom_range(0, 10)];
                if ($urandom_range(0, 9) == 0) fn32 = 6'($urandom);
                if (fn32 == F_MULTU) fn32 = F_ADD;
                sh32 = 5'($urandom);
                a32 = $urandom;
                b32 = $urandom;
                if ($urandom_range(0, 7) == 0) b32 = a32;
                v32 = 1'b1;
                e_prev = ref32(op32, fn32, sh32, a32, b32, m_hi, m_lo);
            end else begin
                v32 = 1'b0;
            end
        end
    endtask

    task automatic test_abort;
        int seen;
        @(negedge clk);
        op32 = 2'b10; fn32 = F_MULTU; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; v32 = 1'b1;
        @(posedge clk);
        #1 v32 = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ov32, rdy32, hi32, lo32} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL abort_reset: got ov=%b rdy=%b hi=%h lo=%h expected ov=0 rdy=1 hi=0 lo=0", ov32, rdy32, hi32, lo32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 0;
        m_lo = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov32 !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_no_pulse: got %0d pulses hi=%h lo=%h expected 0 pulses hi=0 lo=0", seen, hi32, lo32);
        end
        do_op32(2'b00, 6'h00, 0, 32'd1, 32'd1);
        tests_run++;
        if ({ov32, ill32, res32} !== {1'b1, 1'b0, 32'd2}) begin
            tests_failed++;
            $display("FAIL add_after_abort: got ov=%b ill=%b res=%h expected 2", ov32, ill32, res32);
        end
    endtask

    task automatic test_width8;
        logic [7:0]  x, y;
        logic [15:0] p;
        int bad;
        @(negedge clk);
        op8 = 2'b00; a8 = 8'd200; b8 = 8'd100; v8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({ov8, ill8, z8, res8} !== {1'b1, 1'b0, 1'b0, 8'd44}) begin
            tests_failed++;
            $display("FAIL w8_add_wrap: got ov=%b z=%b res=%h expected res=2c", ov8, z8, res8);
        end
        for (int i = 0; i < 4; i++) begin
            x = (i == 0) ? 8'd200 : 8'($urandom);
            y = (i == 0) ? 8'd200 : 8'($urandom);
            p = 16'(x) * 16'(y);
            @(negedge clk);
            op8 = 2'b10; fn8 = F_MULTU; a8 = x; b8 = y; v8 = 1'b1;
            @(posedge clk);
            #1 v8 = 1'b0;
            bad = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (rdy8 !== 1'b0 || ov8 !== 1'b0) bad++;
            end
            @(negedge clk);
            tests_run++;
            if (bad != 0 || {ov8, rdy8, ill8, res8, hi8, lo8} !== {1'b1, 1'b1, 1'b0, p[7:0], p[15:8], p[7:0]}) begin
                tests_failed++;
                $display("FAIL w8_mul_%0d: got busy_errs=%0d ov=%b hi=%h lo=%h expected hi=%h lo=%h",
                         i, bad, ov8, hi8, lo8, p[15:8], p[7:0]);
            end
        end
    endtask

    task automatic test_mul_disabled;
        logic [5:0] fns [3];
        fns = '{F_MULTU, F_MFHI, F_MFLO};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opn = 2'b10; fnn = fns[i]; an = 32'd6; bn = 32'd7; vn = 1'b1;
            @(posedge clk);
            #1 vn = 1'b0;
            @(negedge clk);
            tests_run++;
            if ({ovn, rdyn, illn, zn, resn, hin, lon} !== {1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0}) begin
                tests_failed++;
                $display("FAIL nomul_%h: got ov=%b rdy=%b ill=%b z=%b res=%h hi=%h lo=%h expected ov=1 rdy=1 ill=1 z=1 res=0",
                         fns[i], ovn, rdyn, illn, zn, resn, hin, lon);
            end
        end
        @(negedge clk);
        opn = 2'b10; fnn = F_ADD; an = 32'd6; bn = 32'd7; vn = 1'b1;
        @(posedge clk);
        #1 vn = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({ovn, illn, resn} !== {1'b1, 1'b0, 32'd13}) begin
            tests_failed++;
            $display("FAIL nomul_add: got ov=%b ill=%b res=%h expected 0000000d", ovn, illn, resn);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_shifts();
        test_multiply();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_width8();
        test_mul_disabled();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the MIPS core that merges ALU-control decoding (ALUOp + funct) with the datapath, registers its result, and adds a multi-cycle unsigned multiplier with HI/LO registers. It sits between the register-file read stage and writeback. A valid/ready handshake lets the controller stall issue while a multiply is in flight.

## Interface
- WIDTH, 32: datapath width in bits; must be at least 8.
- MUL_EN, 1: 1 enables multu/mfhi/mflo; 0 makes them illegal.
- SH_W, $clog2(WIDTH): derived shift-amount width; not overridden.

- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; handshake occurs when in_valid && in_ready
- alu_op  in  2  from control unit: 00 add (lw/sw), 01 sub (beq), 10 use funct, 11 illegal
- funct  in  6  R-format funct field
- shamt  in  SH_W  shift amount for sll/srl
- a, b  in  WIDTH  operands (rs, rt)
- out_valid  out  1  one-cycle pulse, result fields valid
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- illegal  out  1  registered, qualifies out_valid
- hi, lo  out  WIDTH  multiply result registers

## Operation
- Decode when alu_op=10:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor
  - 101010 slt (signed compare, result 1/0)
  - 000000 sll b by shamt, 000010 srl b by shamt (logical)
  - 011001 multu, 010000 mfhi, 010010 mflo
  - Any other code: illegal.
- add and sub wrap modulo 2^WIDTH. No overflow flag, no trap.
- Illegal op: out_valid still pulses with illegal=1, result=0, zero=1. hi/lo are unchanged.
- FSM states are IDLE and MUL.
  - IDLE: in_ready=1.
  - Accepted single-cycle op: stay in IDLE.
  - Accepted multu (MUL_EN=1): latch a and b, clear the accumulator, set counter=WIDTH, go to MUL.
  - MUL: in_ready=0. Perform one shift-add step (multiplicand shifted left, multiplier shifted right, add when multiplier LSB=1) per cycle and decrement the counter.
  - When counter reaches 0: write hi/lo with the 2*WIDTH product, pulse out_valid with result=lo and illegal=0, return to IDLE.
- mfhi/mflo return the current hi/lo. They cannot overlap a multiply, because in_ready is low during MUL.
- in_valid while in_ready=0 is ignored, not queued. The issuer holds the op.
- No output backpressure: out_valid is a pulse and the consumer must capture it.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0, hi=0, lo=0, counter=0.
- Reset asserted mid-multiply aborts the operation immediately. No out_valid is produced and hi/lo read 0.

## Timing
- Single-cycle op accepted at edge k: out_valid, result, zero and illegal are high/valid for the cycle after edge k only (latency 1).
- Back-to-back single-cycle ops sustain 1 op/cycle with in_ready held at 1.
- multu accepted at edge k:
  - in_ready=0 from edge k until edge k+WIDTH.
  - At edge k+WIDTH: hi/lo update, out_valid pulses, in_ready returns to 1.
  - A new op may be accepted at edge k+WIDTH+1 (latency WIDTH, issue interval WIDTH+1).
- hi/lo change only at multiply completion or reset.
- zero is derived from the registered result. It is never combinational from the inputs.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs go to reset values before the next edge; in_ready=1.
- Decode sweep, WIDTH=32:
  - a=7, b=5 through add/sub/and/or/nor/slt gives 12, 2, 5, 7, 0xFFFFFFF8, 0, each out_valid one cycle after accept.
  - a=0xFFFFFFFF, b=1, slt -> 1.
  - alu_op=01 with a=b=9 -> result=0, zero=1.
- Shifts and illegals:
  - sll b=1, shamt=31 -> 0x80000000; srl b=0x80000000, shamt=31 -> 1.
  - funct 111111 -> illegal=1, result=0, hi/lo unchanged.
  - alu_op=11 -> illegal=1.
- Multiply, WIDTH=32:
  - multu a=0xFFFFFFFF, b=0xFFFFFFFF -> in_ready low 32 cycles; out_valid at accept+32 with hi=0xFFFFFFFE, lo=0x00000001, result=1.
  - mfhi issued while in_ready=0 is not accepted; after completion it returns 0xFFFFFFFE.
- Abort: reset at cycle 10 of a multiply -> no out_valid pulse, hi=lo=0; a following add of 1+1 returns 2.
- Parameter variants:
  - WIDTH=8, multu 200*200 -> hi=0x9C, lo=0x40 after 8 cycles.
  - MUL_EN=0: multu -> illegal=1 with a single-cycle response.
